// File: rtl/guess_input_ctrl_pkg.sv
// Shared constants and types for the button front end.
//   GUESS_W                 : width of user_guess / mole position
//   N_BTN                   : number of position buttons (one per mole position)
//   DEBOUNCE_CYCLES_DEFAULT : 10 ms at 100 MHz, shared so every user of the
//                             debounce width agrees on it
//   fsm_state_e             : press-acceptance FSM states
package guess_input_ctrl_pkg;

  localparam int GUESS_W                 = 3;
  localparam int N_BTN                   = 8;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef enum logic {
    ARMED    = 1'b0,
    WAIT_REL = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchronizer followed by a stability counter for one raw input.
// The output level changes only after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   raw   : asynchronous raw input
//   level : debounced (stable) level, registered
module debounce_cell
  import guess_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      level     <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // Any sample agreeing with the current level restarts the count, so a
      // glitch shorter than DEBOUNCE_CYCLES can never flip the level.
      if (sync2_reg == level) begin
        cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
        level   <= sync2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/guess_input_ctrl.sv
// Board-button front end for main_no_buttons. Debounces 8 position buttons
// and a restart button, turns a single accepted press into user_guess plus a
// one-cycle eval_now strobe, and exports restart as a debounced level.
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   btn_raw      : raw position buttons, bit i = mole position i
//   restart_raw  : raw restart button
//   user_guess   : index of the last accepted press, held
//   eval_now     : one-cycle strobe, user_guess valid in the same cycle
//   restart_game : debounced restart level (registered)
//   multi_press  : one-cycle strobe when a press is rejected (>1 button down)
//   btn_db       : debounced button levels
module guess_input_ctrl
  import guess_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BTN-1:0]   btn_raw,
  input  logic               restart_raw,
  output logic [GUESS_W-1:0] user_guess,
  output logic               eval_now,
  output logic               restart_game,
  output logic               multi_press,
  output logic [N_BTN-1:0]   btn_db
);

  logic       restart_db;
  fsm_state_e state_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw[gi]),
        .level (btn_db[gi])
      );
    end
  endgenerate

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_restart_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (restart_raw),
    .level (restart_db)
  );

  // Popcount and index of the set bit. The index is only used when exactly
  // one bit is set, so plain "last set bit wins" encoding is sufficient.
  logic [3:0]         ones_cnt;
  logic [GUESS_W-1:0] btn_idx;

  always_comb begin
    ones_cnt = '0;
    btn_idx  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      ones_cnt = ones_cnt + 4'(btn_db[i]);
      if (btn_db[i]) btn_idx = GUESS_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ARMED;
      user_guess   <= '0;
      eval_now     <= 1'b0;
      multi_press  <= 1'b0;
      restart_game <= 1'b0;
    end else begin
      eval_now     <= 1'b0;
      multi_press  <= 1'b0;
      restart_game <= restart_db;
      case (state_reg)
        ARMED: begin
          if (ones_cnt == 4'd1) begin
            // While restart is held the press is swallowed, but we still wait
            // for release so it cannot fire once restart drops.
            if (!restart_game) begin
              eval_now   <= 1'b1;
              user_guess <= btn_idx;
            end
            state_reg <= WAIT_REL;
          end else if (ones_cnt > 4'd1) begin
            multi_press <= 1'b1;
            state_reg   <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (btn_db == '0) state_reg <= ARMED;
        end
        default: state_reg <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_input_ctrl.sv
module tb_guess_input_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] btn_raw = '0;
  logic       restart_raw = 1'b0;
  logic [2:0] user_guess;
  logic       eval_now;
  logic       restart_game;
  logic       multi_press;
  logic [7:0] btn_db;

  int checks = 0;
  int errors = 0;

  guess_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .restart_raw  (restart_raw),
    .user_guess   (user_guess),
    .eval_now     (eval_now),
    .restart_game (restart_game),
    .multi_press  (multi_press),
    .btn_db       (btn_db)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Each input is seen two clocks late; its debounced level flips after D
  // consecutive delayed samples disagree with it. Acceptance: from an idle
  // (all released) condition, the first non-zero debounced pattern decides
  // the outcome, then nothing more happens until everything is released.
  logic [8:0] m_d1, m_d2, m_lvl;
  int         m_run [9];
  logic       m_idle, m_eval, m_multi, m_rg;
  logic [2:0] m_guess;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0;
      for (int k = 0; k < 9; k++) m_run[k] = 0;
      m_idle = 1'b1; m_eval = 1'b0; m_multi = 1'b0; m_rg = 1'b0; m_guess = '0;
    end else begin
      m_eval  = 1'b0;
      m_multi = 1'b0;
      if (m_idle) begin
        if ($countones(m_lvl[7:0]) == 1) begin
          if (!m_rg) begin
            m_eval = 1'b1;
            for (int k = 0; k < 8; k++) if (m_lvl[k]) m_guess = 3'(k);
          end
          m_idle = 1'b0;
        end else if ($countones(m_lvl[7:0]) > 1) begin
          m_multi = 1'b1;
          m_idle  = 1'b0;
        end
      end else if (m_lvl[7:0] == 8'h00) begin
        m_idle = 1'b1;
      end
      m_rg = m_lvl[8];
      for (int k = 0; k < 9; k++) begin
        if (m_d2[k] != m_lvl[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == D) begin
            m_lvl[k] = m_d2[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = {restart_raw, btn_raw};
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("eval_now",     int'(eval_now),     int'(m_eval));
      chk("multi_press",  int'(multi_press),  int'(m_multi));
      chk("user_guess",   int'(user_guess),   int'(m_guess));
      chk("restart_game", int'(restart_game), int'(m_rg));
      chk("btn_db",       int'(btn_db),       int'(m_lvl[7:0]));
    end
  end

  // Strobe monitor used by the directed tests.
  int         ev_count = 0;
  int         mp_count = 0;
  logic [2:0] last_guess = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (eval_now) begin
        ev_count++;
        last_guess = user_guess;
      end
      if (multi_press) mp_count++;
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int first_db, first_ev, first_mev, rise, fall;
  logic db_moved;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_eval",  int'(eval_now), 0);
    chk("reset_guess", int'(user_guess), 0);
    chk("reset_db",    int'(btn_db), 0);
    chk("reset_rg",    int'(restart_game), 0);

    // --- single press, bit 2 held from before edge 1 ---
    rst = 1'b0;
    btn_raw = 8'b0000_0100;
    ev_count = 0;
    first_db = 0; first_ev = 0; first_mev = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (btn_db[2] && first_db == 0) first_db = i;
      if (eval_now && first_ev == 0) first_ev = i;
      if (m_eval && first_mev == 0) first_mev = i;
    end
    chk("single_db_edge",    first_db, 6);
    chk("single_eval_edge",  first_ev, 7);
    chk("model_eval_edge",   first_mev, 7);
    chk("single_eval_count", ev_count, 1);
    chk("single_guess",      int'(last_guess), 2);
    btn_raw = '0;
    cycles(12);

    // --- bounce on bit 5: high 3, low 2, then steady high ---
    ev_count = 0;
    db_moved = 1'b0;
    btn_raw = 8'b0010_0000;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) btn_raw = 8'h00;
      @(negedge clk);
      if (btn_db != 8'h00) db_moved = 1'b1;
    end
    chk("bounce_no_db", int'(db_moved), 0);
    btn_raw = 8'b0010_0000;
    cycles(14);
    chk("bounce_eval_count", ev_count, 1);
    chk("bounce_guess",      int'(last_guess), 5);
    btn_raw = '0;
    cycles(12);

    // --- multi-press, then a clean press of bit 3 ---
    ev_count = 0; mp_count = 0;
    btn_raw = 8'b1000_0001;
    cycles(14);
    chk("multi_count",      mp_count, 1);
    chk("multi_no_eval",    ev_count, 0);
    chk("multi_guess_held", int'(user_guess), 5);
    btn_raw = '0;
    cycles(12);
    btn_raw = 8'b0000_1000;
    cycles(14);
    chk("after_multi_eval",  ev_count, 1);
    chk("after_multi_guess", int'(last_guess), 3);
    btn_raw = '0;
    cycles(12);

    // --- hold bit 1, add bit 6, release, then bit 6 alone ---
    ev_count = 0; mp_count = 0;
    btn_raw = 8'b0000_0010;
    cycles(12);
    btn_raw = 8'b0100_0010;
    cycles(14);
    chk("hold_eval_count", ev_count, 1);
    chk("hold_guess",      int'(last_guess), 1);
    chk("hold_no_multi",   mp_count, 0);
    btn_raw = '0;
    cycles(12);
    btn_raw = 8'b0100_0000;
    cycles(14);
    chk("second_eval_count", ev_count, 2);
    chk("second_guess",      int'(last_guess), 6);
    btn_raw = '0;
    cycles(12);

    // --- restart for 20 cycles with a press of bit 0 inside it ---
    ev_count = 0;
    rise = 0; fall = 0;
    restart_raw = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (restart_game && rise == 0) rise = i;
      if (!restart_game && rise != 0 && fall == 0) fall = i;
      if (i == 8)  btn_raw = 8'b0000_0001;
      if (i == 16) btn_raw = 8'h00;
      if (i == 20) restart_raw = 1'b0;
    end
    chk("restart_rise", rise, 7);
    chk("restart_fall", fall, 27);
    chk("restart_no_eval", ev_count, 0);
    cycles(4);

    // --- async reset mid-debounce with bit 4 held ---
    btn_raw = 8'b0001_0000;
    cycles(4);
    #2 rst = 1'b1;
    #1;
    chk("arst_guess", int'(user_guess), 0);
    chk("arst_db",    int'(btn_db), 0);
    chk("arst_eval",  int'(eval_now), 0);
    chk("arst_multi", int'(multi_press), 0);
    chk("arst_rg",    int'(restart_game), 0);
    @(negedge clk);
    rst = 1'b0;
    ev_count = 0;
    first_ev = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (eval_now && first_ev == 0) first_ev = i;
    end
    chk("arst_eval_edge",  first_ev, 7);
    chk("arst_eval_count", ev_count, 1);
    chk("arst_guess_new",  int'(last_guess), 4);
    btn_raw = '0;
    cycles(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
